lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the load/store buffer. Accepts one memory operation at a time from the buffer, sequences it through the memory controller's request/ok handshake, sign- or zero-extends load data, and broadcasts load results on the common result bus (consumed by RS, LSB and RoB). Handles rollback by squashing in-flight loads while letting committed stores finish.

## Interface
- No parameters; instruction encodings `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW come from defines.v (load iff inst_name <= `LHU).
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- en_signal_from_lsb  input  1  one-cycle issue strobe
- inst_name_from_lsb  input  6  operation
- mem_addr_from_lsb  input  32  effective address
- store_value_from_lsb  input  32  store data (low bytes used)
- rob_id_from_lsb  input  5  destination RoB tag (0 = none)
- busy_to_lsb  output  1  combinational: state != IDLE or en_signal_from_lsb
- en_signal_to_memctrl  output  1  memory request, held until ok
- wr_flag_to_memctrl  output  1  1 = store
- addr_to_memctrl  output  32  address
- len_to_memctrl  output  3  byte count: 1, 2 or 4
- data_to_memctrl  output  32  store data
- ok_flag_from_memctrl  input  1  one-cycle completion pulse
- data_from_memctrl  input  32  load data, zero-filled above len
- valid_to_cdb  output  1  one-cycle load-result pulse
- result_to_cdb  output  32  extended load value
- rob_id_to_cdb  output  5  tag of result
- rollback_flag_from_rob  input  1  misprediction flush

## Operation
- States: IDLE, WAIT_MEM. Latched registers: op, addr, store data, rob_id, squash flag.
- IDLE + en (rdy_in high): latch inputs; drive en_signal_to_memctrl=1, wr_flag, addr, len (LB/LBU/SB=1, LH/LHU/SH=2, LW/SW=4), data; go WAIT_MEM.
- WAIT_MEM: hold all memctrl outputs stable until ok_flag_from_memctrl. On ok: drop en_signal_to_memctrl, go IDLE; if load and not squashed, assert valid_to_cdb with rob_id_to_cdb=latched tag.
- Extension: LB sign-extends bit 7, LH bit 15, LBU/LHU zero-extend, LW passes 32 bits.
- Stores never produce valid_to_cdb.
- Rollback: in WAIT_MEM with a load, set squash; transaction still runs to ok (memctrl never aborted), result discarded. Pending store unaffected. en arriving in rollback cycle: store accepted, load ignored (stays IDLE). ok and rollback in same cycle: no valid pulse.
- rdy_in low: every register holds; valid_to_cdb forced 0 that cycle and pulse re-emitted when rdy returns.
- Reset (rst_in low, any time incl. mid-transaction): state IDLE, squash 0, all outputs 0 (en_signal_to_memctrl, wr_flag, addr, len, data, valid_to_cdb, result_to_cdb, rob_id_to_cdb).

## Timing
- en at cycle N -> en_signal_to_memctrl high from N+1.
- ok at cycle M -> valid_to_cdb high exactly at M+1, one cycle; state IDLE at M+1.
- busy_to_lsb high from N (combinational on en) through M inclusive; low at M+1, so LSB may issue at M+1 and a new request reaches memctrl at M+2.
- Back-to-back: at most one outstanding operation; no queuing.
- Load latency = memctrl latency + 1 cycle.

## Test plan
- LW addr 0x1000, memctrl returns 0xDEADBEEF after 4 cycles -> len=4, wr=0, valid pulse one cycle after ok, result 0xDEADBEEF, rob_id 7.
- LB data 0x80 -> result 0xFFFFFF80; LBU data 0x80 -> 0x00000080; LH 0x8001 -> 0xFFFF8001.
- SH addr 0x2002 value 0x1234ABCD -> en/wr=1, len=2, data 0x1234ABCD held until ok, no valid pulse.
- LW issued, rollback 2 cycles later -> memctrl request held to ok, no valid pulse, busy low after ok; SW issued with rollback same cycle -> store completes.
- rdy_in low for 3 cycles spanning ok -> no pulse while low, single pulse after; rst_in low mid-WAIT_MEM -> all outputs 0 immediately, busy_to_lsb 0.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: bundles the load/store unit's bus-side signals.
//   LSB side     : en/inst_name/mem_addr/store_value/rob_id in, busy out
//   memctrl side : en/wr/addr/len/data out, ok/data in
//   CDB side     : valid/result/rob_id out
//   RoB side     : rollback flag in
// modport slave  = the lsu itself
// modport master = the surrounding pipeline / memory controller
interface lsu_if;
    logic        en_signal_from_lsb;
    logic [5:0]  inst_name_from_lsb;
    logic [31:0] mem_addr_from_lsb;
    logic [31:0] store_value_from_lsb;
    logic [4:0]  rob_id_from_lsb;
    logic        busy_to_lsb;

    logic        en_signal_to_memctrl;
    logic        wr_flag_to_memctrl;
    logic [31:0] addr_to_memctrl;
    logic [2:0]  len_to_memctrl;
    logic [31:0] data_to_memctrl;
    logic        ok_flag_from_memctrl;
    logic [31:0] data_from_memctrl;

    logic        valid_to_cdb;
    logic [31:0] result_to_cdb;
    logic [4:0]  rob_id_to_cdb;

    logic        rollback_flag_from_rob;

    modport slave (
        input  en_signal_from_lsb, inst_name_from_lsb, mem_addr_from_lsb,
               store_value_from_lsb, rob_id_from_lsb,
               ok_flag_from_memctrl, data_from_memctrl, rollback_flag_from_rob,
        output busy_to_lsb, en_signal_to_memctrl, wr_flag_to_memctrl,
               addr_to_memctrl, len_to_memctrl, data_to_memctrl,
               valid_to_cdb, result_to_cdb, rob_id_to_cdb
    );

    modport master (
        output en_signal_from_lsb, inst_name_from_lsb, mem_addr_from_lsb,
               store_value_from_lsb, rob_id_from_lsb,
               ok_flag_from_memctrl, data_from_memctrl, rollback_flag_from_rob,
        input  busy_to_lsb, en_signal_to_memctrl, wr_flag_to_memctrl,
               addr_to_memctrl, len_to_memctrl, data_to_memctrl,
               valid_to_cdb, result_to_cdb, rob_id_to_cdb
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit downstream of the load/store buffer.
// Takes one memory operation at a time, runs it through the memory
// controller's request/ok handshake, extends load data and broadcasts the
// result on the CDB. Rollback squashes an in-flight load's result but the
// memory transaction itself always runs to completion.
// Ports:
//   clk_in  - system clock
//   rst_in  - asynchronous active-low reset
//   rdy_in  - global ready; low freezes every register
//   bus     - lsu_if.slave (LSB issue, memctrl handshake, CDB, rollback)
// Operation encodings: LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8
// (loads are exactly the codes <= LHU).
module lsu (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    lsu_if.slave  bus
);
    localparam logic [5:0] LB  = 6'd1;
    localparam logic [5:0] LH  = 6'd2;
    localparam logic [5:0] LW  = 6'd3;
    localparam logic [5:0] LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5;
    localparam logic [5:0] SB  = 6'd6;
    localparam logic [5:0] SH  = 6'd7;
    localparam logic [5:0] SW  = 6'd8;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0]  state_reg;
    logic [5:0]  op_reg;
    logic [31:0] addr_reg;
    logic [31:0] sdata_reg;
    logic [4:0]  rob_reg;
    logic        squash_reg;
    logic        valid_reg;
    logic [31:0] result_reg;
    logic [4:0]  cdb_rob_reg;

    logic        in_is_load;
    logic        op_is_load;
    logic        accept;
    logic [31:0] ext_data;

    function automatic logic [2:0] len_of(input logic [5:0] op);
        case (op)
            LB, LBU, SB: len_of = 3'd1;
            LH, LHU, SH: len_of = 3'd2;
            LW, SW:      len_of = 3'd4;
            default:     len_of = 3'd0;  // only seen out of reset
        endcase
    endfunction

    assign in_is_load = (bus.inst_name_from_lsb <= LHU);
    assign op_is_load = (op_reg <= LHU);

    // A load issued in the same cycle as a rollback is already stale and is
    // dropped; a store at that point is committed and must proceed.
    assign accept = (state_reg == IDLE) && bus.en_signal_from_lsb &&
                    !(bus.rollback_flag_from_rob && in_is_load);

    always_comb begin
        ext_data = bus.data_from_memctrl;
        case (op_reg)
            LB:      ext_data = {{24{bus.data_from_memctrl[7]}},  bus.data_from_memctrl[7:0]};
            LH:      ext_data = {{16{bus.data_from_memctrl[15]}}, bus.data_from_memctrl[15:0]};
            LBU:     ext_data = {24'd0, bus.data_from_memctrl[7:0]};
            LHU:     ext_data = {16'd0, bus.data_from_memctrl[15:0]};
            default: ext_data = bus.data_from_memctrl;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg   <= IDLE;
            op_reg      <= 6'd0;
            addr_reg    <= 32'd0;
            sdata_reg   <= 32'd0;
            rob_reg     <= 5'd0;
            squash_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            result_reg  <= 32'd0;
            cdb_rob_reg <= 5'd0;
        end else if (rdy_in) begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg  <= WAIT_MEM;
                        op_reg     <= bus.inst_name_from_lsb;
                        addr_reg   <= bus.mem_addr_from_lsb;
                        sdata_reg  <= bus.store_value_from_lsb;
                        rob_reg    <= bus.rob_id_from_lsb;
                        squash_reg <= 1'b0;
                    end
                end
                default: begin
                    if (bus.rollback_flag_from_rob && op_is_load)
                        squash_reg <= 1'b1;
                    if (bus.ok_flag_from_memctrl) begin
                        state_reg <= IDLE;
                        // Rollback coinciding with ok also kills the result.
                        if (op_is_load && !squash_reg && !bus.rollback_flag_from_rob) begin
                            valid_reg   <= 1'b1;
                            result_reg  <= ext_data;
                            cdb_rob_reg <= rob_reg;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy_to_lsb          = (state_reg != IDLE) || bus.en_signal_from_lsb;
    assign bus.en_signal_to_memctrl = (state_reg == WAIT_MEM);
    assign bus.wr_flag_to_memctrl   = !op_is_load;
    assign bus.addr_to_memctrl      = addr_reg;
    assign bus.len_to_memctrl       = len_of(op_reg);
    assign bus.data_to_memctrl      = sdata_reg;
    // While rdy is low the pulse is hidden; valid_reg holds so it reappears.
    assign bus.valid_to_cdb         = valid_reg && rdy_in;
    assign bus.result_to_cdb        = result_reg;
    assign bus.rob_id_to_cdb        = cdb_rob_reg;
endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    localparam logic [5:0] LB  = 6'd1;
    localparam logic [5:0] LH  = 6'd2;
    localparam logic [5:0] LW  = 6'd3;
    localparam logic [5:0] LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5;
    localparam logic [5:0] SB  = 6'd6;
    localparam logic [5:0] SH  = 6'd7;
    localparam logic [5:0] SW  = 6'd8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    lsu_if bus();

    lsu dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Reference model: byte count and extension from the operation's meaning.
    function automatic int ref_len(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [31:0] raw);
        longint v;
        v = longint'(raw);
        if (op == LB)  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
        if (op == LH)  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
        if (op == LBU) v = v % 256;
        if (op == LHU) v = v % 65536;
        return v[31:0];
    endfunction

    // One full operation: issue, hold-check during memctrl latency, ok,
    // result check. rb_at = wait-cycle index where rollback pulses (-1 none,
    // lat-1 means together with ok); rb_with_en = rollback on the issue cycle;
    // rdy_gap = cycles of rdy low right after ok is taken.
    task automatic run_op(input int id, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] val, input logic [4:0] rob, input int lat,
                          input int rb_at, input bit rb_with_en, input int rdy_gap);
        bit ld;
        bit squashed;
        bit exp_valid;
        int len;
        logic [31:0] raw;
        ld  = (op <= LHU);
        len = ref_len(op);
        raw = (len == 4) ? val : 32'(longint'(val) % (longint'(1) << (8 * len)));
        squashed = 1'b0;

        bus.en_signal_from_lsb     = 1'b1;
        bus.inst_name_from_lsb     = op;
        bus.mem_addr_from_lsb      = addr;
        bus.store_value_from_lsb   = val;
        bus.rob_id_from_lsb        = rob;
        bus.rollback_flag_from_rob = rb_with_en;
        #1;
        chk("busy_on_issue", bus.busy_to_lsb, 1);
        step();
        bus.en_signal_from_lsb     = 1'b0;
        bus.rollback_flag_from_rob = 1'b0;
        bus.inst_name_from_lsb     = 6'(($urandom_range(1, 8)));
        bus.mem_addr_from_lsb      = $urandom;
        bus.store_value_from_lsb   = $urandom;
        #1;

        if (rb_with_en && ld) begin
            $display("txn %0d op=%0d addr=%08h val=%08h rob=%0d dropped by rollback", id, op, addr, val, rob);
            chk("dropped_req_en", bus.en_signal_to_memctrl, 0);
            chk("dropped_busy", bus.busy_to_lsb, 0);
            return;
        end

        chk("req_en", bus.en_signal_to_memctrl, 1);
        chk("req_wr", bus.wr_flag_to_memctrl, ld ? 0 : 1);
        chk("req_addr", bus.addr_to_memctrl, addr);
        chk("req_len", bus.len_to_memctrl, len);
        if (!ld) chk("req_data", bus.data_to_memctrl, val);

        for (int i = 0; i < lat - 1; i++) begin
            if (i == rb_at) begin
                bus.rollback_flag_from_rob = 1'b1;
                if (ld) squashed = 1'b1;
            end
            step();
            bus.rollback_flag_from_rob = 1'b0;
            chk("hold_en", bus.en_signal_to_memctrl, 1);
            chk("hold_addr", bus.addr_to_memctrl, addr);
            if (!ld) chk("hold_data", bus.data_to_memctrl, val);
            chk("hold_busy", bus.busy_to_lsb, 1);
            chk("hold_no_valid", bus.valid_to_cdb, 0);
        end

        bus.ok_flag_from_memctrl = 1'b1;
        bus.data_from_memctrl    = raw;
        if (rb_at == lat - 1) begin
            bus.rollback_flag_from_rob = 1'b1;
            if (ld) squashed = 1'b1;
        end
        #1;
        chk("busy_at_ok", bus.busy_to_lsb, 1);
        step();
        bus.ok_flag_from_memctrl   = 1'b0;
        bus.rollback_flag_from_rob = 1'b0;
        bus.data_from_memctrl      = $urandom;
        exp_valid = ld && !squashed;

        if (rdy_gap > 0) begin
            rdy_in = 1'b0;
            #1;
            for (int g = 0; g < rdy_gap; g++) begin
                chk("valid_while_rdy_low", bus.valid_to_cdb, 0);
                step();
            end
            rdy_in = 1'b1;
        end
        #1;
        chk("cdb_valid", bus.valid_to_cdb, exp_valid);
        if (exp_valid) begin
            chk("cdb_result", bus.result_to_cdb, ref_ext(op, raw));
            chk("cdb_rob", bus.rob_id_to_cdb, rob);
        end
        chk("busy_after_ok", bus.busy_to_lsb, 0);
        chk("req_dropped", bus.en_signal_to_memctrl, 0);
        step();
        chk("valid_one_cycle", bus.valid_to_cdb, 0);

        $display("txn %0d op=%0d addr=%08h val=%08h rob=%0d lat=%0d rb_at=%0d rb_en=%0d rdy_gap=%0d valid=%0d result=%08h",
                 id, op, addr, val, rob, lat, rb_at, rb_with_en, rdy_gap, exp_valid, exp_valid ? ref_ext(op, raw) : 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, bus.en_signal_to_memctrl, 0);
        chk({tag, "_wr"},     bus.wr_flag_to_memctrl, 0);
        chk({tag, "_addr"},   bus.addr_to_memctrl, 0);
        chk({tag, "_len"},    bus.len_to_memctrl, 0);
        chk({tag, "_data"},   bus.data_to_memctrl, 0);
        chk({tag, "_valid"},  bus.valid_to_cdb, 0);
        chk({tag, "_result"}, bus.result_to_cdb, 0);
        chk({tag, "_rob"},    bus.rob_id_to_cdb, 0);
        chk({tag, "_busy"},   bus.busy_to_lsb, 0);
    endtask

    initial begin
        int lat;
        int rb_at;
        bit rb_en;
        int gap;
        logic [5:0] op;

        bus.en_signal_from_lsb     = 1'b0;
        bus.inst_name_from_lsb     = 6'd0;
        bus.mem_addr_from_lsb      = 32'd0;
        bus.store_value_from_lsb   = 32'd0;
        bus.rob_id_from_lsb        = 5'd0;
        bus.ok_flag_from_memctrl   = 1'b0;
        bus.data_from_memctrl      = 32'd0;
        bus.rollback_flag_from_rob = 1'b0;

        step();
        step();
        chk_all_zero("reset");
        rst_in = 1'b1;
        step();

        // Directed cases
        run_op(1, LW, 32'h0000_1000, 32'hDEAD_BEEF, 5'd7, 4, -1, 1'b0, 0);
        run_op(2, LB, 32'h0000_0010, 32'h0000_0080, 5'd3, 2, -1, 1'b0, 0);
        run_op(3, LBU, 32'h0000_0011, 32'h0000_0080, 5'd4, 1, -1, 1'b0, 0);
        run_op(4, LH, 32'h0000_0012, 32'h0000_8001, 5'd5, 3, -1, 1'b0, 0);
        run_op(5, SH, 32'h0000_2002, 32'h1234_ABCD, 5'd9, 3, -1, 1'b0, 0);
        run_op(6, LW, 32'h0000_3000, 32'h1111_2222, 5'd10, 5, 1, 1'b0, 0);
        run_op(7, SW, 32'h0000_4000, 32'hCAFE_F00D, 5'd11, 3, -1, 1'b1, 0);
        run_op(8, LB, 32'h0000_4001, 32'h0000_00FF, 5'd12, 2, -1, 1'b1, 0);
        run_op(9, LW, 32'h0000_5000, 32'h8765_4321, 5'd13, 3, -1, 1'b0, 3);
        run_op(10, LH, 32'h0000_6000, 32'h0000_7FFE, 5'd14, 3, 2, 1'b0, 0);
        run_op(11, LHU, 32'h0000_6002, 32'h0000_F00F, 5'd15, 2, -1, 1'b0, 0);

        // Reset in the middle of a transaction
        bus.en_signal_from_lsb   = 1'b1;
        bus.inst_name_from_lsb   = SW;
        bus.mem_addr_from_lsb    = 32'h0000_7000;
        bus.store_value_from_lsb = 32'h5555_AAAA;
        bus.rob_id_from_lsb      = 5'd16;
        step();
        bus.en_signal_from_lsb = 1'b0;
        step();
        rst_in = 1'b0;
        #1;
        chk_all_zero("midreset");
        $display("txn 12 reset asserted during WAIT_MEM");
        step();
        rst_in = 1'b1;
        step();

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            op    = 6'($urandom_range(1, 8));
            lat   = $urandom_range(1, 6);
            rb_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
            rb_en = ($urandom_range(0, 5) == 0);
            gap   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            run_op(100 + t, op, $urandom, $urandom, 5'($urandom_range(0, 31)), lat, rb_at, rb_en, gap);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
